// File: rtl/instr_encoder.sv
// instr_encoder: turns a decoded operation request into an RV32I instruction word
// and queues it in a 2-entry FIFO. HALT enqueues 32'hFFFF_FFFF and makes the block
// sticky-halted. Optional build macro INSTR_ENC_IMM_CHECK_EN drops requests whose
// immediate does not fit the target format; otherwise immediates are truncated.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_class,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        halted,
    output logic        err
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    logic [31:0] mem_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        halted_q, err_q;

    logic [31:0] enc_word;
    logic        op_legal, imm_ok, is_shift;
    logic        accept, push, pop;

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Field placement for each op class; unknown classes flag op_legal low.
    always_comb begin
        enc_word = '0;
        op_legal = 1'b1;
        case (op_class)
            4'd0: enc_word = {imm[11:0], rs1, 3'b010, rd, OpLoad};
            4'd1: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OpStore};
            4'd2: enc_word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OpReg};
            4'd3: begin
                if (is_shift) begin
                    enc_word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OpImm};
                end else begin
                    enc_word = {imm[11:0], rs1, funct3, rd, OpImm};
                end
            end
            4'd4: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpBranch};
            4'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
            4'd6: enc_word = {imm[11:0], rs1, 3'b000, rd, OpJalr};
            4'd7: enc_word = {imm[31:12], rd, OpLui};
            4'd8: enc_word = 32'hFFFF_FFFF;
            default: op_legal = 1'b0;
        endcase
    end

`ifdef INSTR_ENC_IMM_CHECK_EN
    logic fits12, fits13, fits21;
    // A signed N-bit value has all bits from N-1 upward equal.
    assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fits21 = (&imm[31:20]) || !(|imm[31:20]);

    // Range check of the immediate against the selected format.
    always_comb begin
        imm_ok = 1'b1;
        case (op_class)
            4'd0, 4'd1, 4'd6: imm_ok = fits12;
            4'd3:             imm_ok = is_shift ? (imm[11:5] == 7'd0) : fits12;
            4'd4:             imm_ok = fits13 && !imm[0];
            4'd5:             imm_ok = fits21 && !imm[0];
            4'd7:             imm_ok = (imm[11:0] == 12'd0);
            default:          imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign in_ready  = (count_q != 2'd2) && !halted_q;
    assign accept    = in_valid && in_ready;
    assign push      = accept && op_legal && imm_ok;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign halted    = halted_q;
    assign err       = err_q;

    // Occupancy: push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // FIFO storage, pointers, sticky halt and the one-cycle drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= enc_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            err_q   <= accept && !(op_legal && imm_ok);
            if (push && (op_class == 4'd8)) begin
                halted_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random stimulus for instr_encoder, checked every
// cycle against a queue-based reference model that encodes with shift/mask arithmetic.
// Honours INSTR_ENC_IMM_CHECK_EN the same way the design build does.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op_class = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        halted;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    logic        m_halted = 1'b0;
    logic        m_err = 1'b0;

    instr_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_class (op_class),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .halted   (halted),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] opcode_of(input int cls);
        case (cls)
            0: return 32'h03;
            1: return 32'h23;
            2: return 32'h33;
            3: return 32'h13;
            4: return 32'h63;
            5: return 32'h6F;
            6: return 32'h67;
            default: return 32'h37;
        endcase
    endfunction

    // Reference encoder built from field shifts and masks.
    function automatic logic [31:0] ref_enc(input int cls, input logic [31:0] f3,
                                            input logic [31:0] b5, input logic [31:0] d,
                                            input logic [31:0] s1, input logic [31:0] s2,
                                            input logic [31:0] im);
        logic [31:0] w;
        if (cls == 8) return 32'hFFFF_FFFF;
        w = opcode_of(cls);
        case (cls)
            0: w = w | (d << 7) | (32'd2 << 12) | (s1 << 15) | ((im & 32'hFFF) << 20);
            1: w = w | ((im & 32'h1F) << 7) | (32'd2 << 12) | (s1 << 15) | (s2 << 20)
                     | (((im >> 5) & 32'h7F) << 25);
            2: w = w | (d << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (b5 << 30);
            3: begin
                w = w | (d << 7) | (f3 << 12) | (s1 << 15);
                if (f3 == 1 || f3 == 5) w = w | ((im & 32'h1F) << 20) | (b5 << 30);
                else w = w | ((im & 32'hFFF) << 20);
            end
            4: w = w | (((im >> 11) & 1) << 7) | (((im >> 1) & 32'hF) << 8) | (f3 << 12)
                     | (s1 << 15) | (s2 << 20) | (((im >> 5) & 32'h3F) << 25)
                     | (((im >> 12) & 1) << 31);
            5: w = w | (d << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 1) << 20)
                     | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 1) << 31);
            6: w = w | (d << 7) | (s1 << 15) | ((im & 32'hFFF) << 20);
            default: w = w | (d << 7) | (im & 32'hFFFFF000);
        endcase
        return w;
    endfunction

    function automatic bit in_range(input longint v, input longint lo, input longint hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic bit ref_legal(input int cls, input logic [31:0] f3, input logic [31:0] im);
        longint v;
        v = longint'($signed(im));
        if (cls > 8) return 1'b0;
`ifdef INSTR_ENC_IMM_CHECK_EN
        case (cls)
            0, 1, 6: return in_range(v, -2048, 2047);
            3: return (f3 == 1 || f3 == 5) ? ((im & 32'hFE0) == 0) : in_range(v, -2048, 2047);
            4: return in_range(v, -4096, 4095) && (v % 2 == 0);
            5: return in_range(v, -1048576, 1048575) && (v % 2 == 0);
            7: return (im & 32'hFFF) == 0;
            default: return 1'b1;
        endcase
`else
        v = v + longint'(f3);
        return 1'b1;
`endif
    endfunction

    // One clock: compare all outputs to the model, then advance the model.
    task automatic step();
        logic exp_ready, exp_valid, acc;
        logic [31:0] exp_instr;
        exp_ready = (mq.size() < 2) && !m_halted;
        exp_valid = (mq.size() > 0);
        exp_instr = exp_valid ? mq[0] : 32'd0;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        chk("out_instr", out_instr, exp_instr);
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("err", {31'd0, err}, {31'd0, m_err});
        acc = in_valid && exp_ready;
        if (exp_valid && out_ready) void'(mq.pop_front());
        m_err = 1'b0;
        if (acc) begin
            if (!ref_legal(int'(op_class), 32'(funct3), imm)) begin
                m_err = 1'b1;
            end else begin
                mq.push_back(ref_enc(int'(op_class), 32'(funct3), 32'(funct7b5), 32'(rd),
                                     32'(rs1), 32'(rs2), imm));
                if (op_class == 4'd8) m_halted = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] c, input logic [2:0] f3, input logic b5,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
        in_valid = 1'b1;
        op_class = c; funct3 = f3; funct7b5 = b5; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Simple ITYPE addi with immediate consumer
        out_ready = 1'b1;
        req(4'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        in_valid = 1'b0;
        chk("addi_word", out_instr, 32'h00500093);
        step();
        chk("addi_single_pulse", {31'd0, out_valid}, 32'd0);

        // Known encodings for store, jal and lui
        req(4'd1, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        step();
        chk("sw_word", out_instr, 32'h0020A423);
        req(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        step();
        chk("jal_word", out_instr, 32'h008000EF);
        req(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        step();
        chk("lui_word", out_instr, 32'h123452B7);
        in_valid = 1'b0;
        step();

        // Backpressure: three requests with the consumer stalled
        out_ready = 1'b0;
        req(4'd2, 3'b000, 1'b1, 5'd3, 5'd4, 5'd5, 32'd0);
        step();
        req(4'd4, 3'b001, 1'b0, 5'd0, 5'd6, 5'd7, 32'hFFFF_FFF8);
        step();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        req(4'd6, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd16);
        step();
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Illegal op class and an oversized ITYPE immediate
        req(4'd12, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        step();
        in_valid = 1'b0;
        chk("illegal_err", {31'd0, err}, 32'd1);
        step();
        req(4'd3, 3'b000, 1'b0, 5'd2, 5'd3, 5'd0, 32'd4096);
        step();
        in_valid = 1'b0;
`ifdef INSTR_ENC_IMM_CHECK_EN
        chk("imm4096_err", {31'd0, err}, 32'd1);
`else
        chk("imm4096_field", 32'(out_instr[31:20]), 32'd0);
`endif
        step();

        // Random traffic, HALT excluded
        for (int i = 0; i < 400; i++) begin
            logic [3:0] c;
            logic [31:0] im;
            c = 4'($urandom_range(0, 15));
            if (c == 4'd8) c = 4'd2;
            im = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom)));
            req(c, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // HALT, then a blocked request while the consumer is stalled
        req(4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        out_ready = 1'b0;
        step();
        chk("halt_word", out_instr, 32'hFFFF_FFFF);
        chk("halt_ready", {31'd0, in_ready}, 32'd0);
        req(4'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        step();
        step();

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_out_instr", out_instr, 32'd0);
        mq.delete();
        m_halted = 1'b0;
        m_err = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        req(4'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
